mem_responder: RTL and testbench

Memory-side responder for the valid/ready memory bus driven by the team's memory BFM. It accepts single read or write requests from the initiator, holds them in a small register array, and answers each request with a one-cycle ready_o pulse. On reads, rdata_o carries the read data. It acts as the reference slave/DUT at the far end of mem_intf, so the bench can check BFM and monitor traffic against a known-good memory.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the valid/ready memory bus: one registered ready_o pulse per request.
// Optional wait states are built when MEM_WAIT_STATE_EN is defined (WAIT_CYCLES extra cycles).
module mem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef MEM_WAIT_STATE_EN
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`endif
  localparam logic [1:0] ST_RESP = 2'd2;

  if (DEPTH == 0 || $clog2(DEPTH) > ADDR_WIDTH || WAIT_CYCLES > 32'hFFFF) begin : g_bad_param
    $error("mem_responder: DEPTH must be 1..2**ADDR_WIDTH and WAIT_CYCLES must fit 16 bits");
  end

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  req_in_range;
  logic [IDX_W-1:0]      req_idx;
  logic                  mem_we;

`ifdef MEM_WAIT_STATE_EN
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
`endif

  // Next state; the access is committed on the edge that enters RESP.
  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    mem_we       = 1'b0;
`ifdef MEM_WAIT_STATE_EN
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_wr       = wr_q;
    req_addr     = addr_q;
    req_wdata    = wdata_q;
`else
    req_wr       = wr_rd_i;
    req_addr     = addr_i;
    req_wdata    = wdata_i;
`endif

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
`ifdef MEM_WAIT_STATE_EN
          req_wr    = wr_rd_i;
          req_addr  = addr_i;
          req_wdata = wdata_i;
          wr_d      = wr_rd_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef MEM_WAIT_STATE_EN
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_in_range = ({1'b0, req_addr} < DEPTH_A);
    req_idx      = IDX_W'(req_addr);

    if (state_d == ST_RESP && state_q != ST_RESP) begin
      ready_d = 1'b1;
      if (req_wr) begin
        mem_we = req_in_range;
      end else begin
        rdata_d = req_in_range ? mem_q[req_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_WAIT_STATE_EN
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
`ifdef MEM_WAIT_STATE_EN
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`endif
    end
  end

  // Storage is deliberately left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[req_idx] <= req_wdata;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 256-word and a 16-word instance share one request stream,
// checked against array models plus directed vectors and reset corner cases.
module tb_mem_responder;

  localparam int unsigned WC = 3;
`ifdef MEM_WAIT_STATE_EN
  localparam int EXP_LAT = 1 + int'(WC);
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        valid;
  logic        wr_rd;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_big, rdata_small;
  logic        ready_big, ready_small;

  int n_pass;
  int n_total;

  logic [31:0] ref_big   [256];
  logic [31:0] ref_small [16];
  logic [31:0] last_big, last_small;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        hold;
    logic [31:0] exp_big;
    logic [31:0] exp_small;
  } vec_t;

  mem_responder #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_CYCLES(WC)) u_big (
    .clk(clk), .rst(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata_big), .ready_o(ready_big)
  );

  mem_responder #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(WC)) u_small (
    .clk(clk), .rst(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata_small), .ready_o(ready_small)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // One request; the bus is scrambled while waiting to prove the captured request is used.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, input bit hold);
    int n;
    valid = 1'b1; wr_rd = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    n = 1;
    while (!ready_big && n < 20) begin
      addr = 8'($urandom); wdata = $urandom; wr_rd = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(EXP_LAT));
    chk("ready_small", 32'(ready_small), 32'd1);
    if (wr) begin
      ref_big[a] = d;
      if (a < 8'd16) ref_small[a[3:0]] = d;
    end else begin
      last_big   = ref_big[a];
      last_small = (a < 8'd16) ? ref_small[a[3:0]] : 32'd0;
    end
    chk(wr ? "rdata_hold_big" : "rdata_big", rdata_big, last_big);
    chk(wr ? "rdata_hold_small" : "rdata_small", rdata_small, last_small);
    @(posedge clk); #1;
    chk("ready_fall_big", 32'(ready_big), 32'd0);
    chk("ready_fall_small", 32'(ready_small), 32'd0);
    if (!hold) valid = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    n_pass = 0; n_total = 0;
    last_big = '0; last_small = '0;
    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 8'h00, 32'h11,       1'b1, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 8'h01, 32'h22,       1'b1, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 8'h02, 32'h33,       1'b1, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 8'h03, 32'h44,       1'b1, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h11,       32'h11};
    vecs[7]  = '{1'b0, 8'h01, 32'h0,        1'b1, 32'h22,       32'h22};
    vecs[8]  = '{1'b0, 8'h02, 32'h0,        1'b1, 32'h33,       32'h33};
    vecs[9]  = '{1'b0, 8'h03, 32'h0,        1'b0, 32'h44,       32'h44};
    vecs[10] = '{1'b1, 8'h20, 32'hAAAA5555, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 8'h20, 32'h0,        1'b0, 32'hAAAA5555, 32'h0};
    vecs[12] = '{1'b0, 8'h00, 32'h0,        1'b0, 32'h11,       32'h11};

    // Asynchronous reset assertion, observed before any clock edge.
    rst = 1'b1; valid = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0;
    #3 rst = 1'b0;
    #1;
    chk("reset_ready", 32'(ready_big), 32'd0);
    chk("reset_rdata", rdata_big, 32'd0);
    chk("reset_rdata_small", rdata_small, 32'd0);
    @(negedge clk) rst = 1'b1;

    // Give every word a known value, back to back.
    for (int i = 0; i < 256; i++) xfer(1'b1, 8'(i), $urandom, 1'b1);
    valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold);
      if (!vecs[i].wr) begin
        chk("tbl_rdata_big", rdata_big, vecs[i].exp_big);
        chk("tbl_rdata_small", rdata_small, vecs[i].exp_small);
      end
    end

    for (int i = 0; i < 150; i++) begin
      logic [7:0] a;
      bit         h;
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      h = 1'($urandom);
      xfer(1'($urandom), a, $urandom, h);
      if (!h) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    valid = 1'b0;
    @(posedge clk); #1;

    // Reset mid-request clears the outputs without waiting for a clock edge.
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 8'h10, 32'h0, 1'b0);
    valid = 1'b1; wr_rd = 1'b0; addr = 8'h10;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midop_rst_ready", 32'(ready_big), 32'd0);
    chk("midop_rst_rdata", rdata_big, 32'd0);
    chk("midop_rst_rdata_small", rdata_small, 32'd0);
    valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    last_big = '0; last_small = '0;
    xfer(1'b1, 8'h07, 32'h5A5A_0707, 1'b0);

`ifdef MEM_WAIT_STATE_EN
    // A write aborted by reset while waiting must leave memory untouched.
    xfer(1'b1, 8'h05, 32'h0BAD_F00D, 1'b0);
    valid = 1'b1; wr_rd = 1'b1; addr = 8'h05; wdata = 32'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_no_ready", 32'(ready_big), 32'd0);
    rst = 1'b0;
    #1;
    valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    last_big = '0; last_small = '0;
    xfer(1'b0, 8'h05, 32'h0, 1'b0);
    chk("abort_no_commit", rdata_big, 32'h0BAD_F00D);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
